// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: selects the next-PC source, gates
// the PC write, flushes IF/ID on redirects and runs a debug halt/drain handshake.
module fetch_ctrl #(
  parameter int BOOT_CYCLES  = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_stall,
  input  logic             jpc_avail,
  input  logic             correct_ex,
  input  logic             correct_mem,
  input  logic             halt_req,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             if_flush,
  output logic [1:0]       npc_sel,
  output logic             halt_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [3:0] DRAIN_MAX = 4'(DRAIN_CYCLES);

  localparam logic [1:0] SEL_SEQ = 2'd0;
  localparam logic [1:0] SEL_JPC = 2'd1;
  localparam logic [1:0] SEL_EX  = 2'd2;
  localparam logic [1:0] SEL_MEM = 2'd3;

  state_t     state, state_nxt;
  logic [3:0] boot_cnt, boot_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic       correct;
  logic       stall_inc, flush_inc;

  assign correct = correct_mem | correct_ex;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BOOT;
      boot_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      boot_cnt  <= boot_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    boot_nxt  = boot_cnt;
    drain_nxt = drain_cnt;
    unique case (state)
      ST_BOOT: begin
        boot_nxt = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) state_nxt = halt_req ? ST_HALT : ST_RUN;
      end
      ST_RUN: begin
        if (halt_req) begin
          state_nxt = ST_HALT;
          drain_nxt = '0;
        end
      end
      ST_HALT: begin
        if (!halt_req) begin
          state_nxt = ST_RUN;
          drain_nxt = '0;
        end else if (correct) begin
          drain_nxt = '0;
        end else if (drain_cnt != DRAIN_MAX) begin
          drain_nxt = drain_cnt + 4'd1;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Corrections win everywhere outside BOOT; sequential/jump fetch only in an unblocked RUN.
  always_comb begin
    pc_write = 1'b0;
    if_flush = 1'b0;
    npc_sel  = SEL_SEQ;
    unique case (state)
      ST_RUN, ST_HALT: begin
        if (correct_mem) begin
          pc_write = 1'b1;
          if_flush = 1'b1;
          npc_sel  = SEL_MEM;
        end else if (correct_ex) begin
          pc_write = 1'b1;
          if_flush = 1'b1;
          npc_sel  = SEL_EX;
        end else if (state == ST_RUN && !id_stall && !halt_req) begin
          pc_write = 1'b1;
          npc_sel  = jpc_avail ? SEL_JPC : SEL_SEQ;
        end
      end
      default: if_flush = 1'b1;
    endcase
  end

  assign halt_ack  = (state == ST_HALT) && (drain_cnt == DRAIN_MAX);

  assign stall_inc = (state == ST_RUN) && !pc_write;
  assign flush_inc = (state != ST_BOOT) && correct;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared on the following falling edge.
module tb_fetch_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_stall, jpc_avail, correct_ex, correct_mem, halt_req, cnt_clr;
  logic             pc_write, if_flush, halt_ack;
  logic [1:0]       npc_sel;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [4:0] outs;  // {pc_write, if_flush, npc_sel, halt_ack}
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  fetch_ctrl #(.BOOT_CYCLES(1), .DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_stall   (id_stall),
    .jpc_avail  (jpc_avail),
    .correct_ex (correct_ex),
    .correct_mem(correct_mem),
    .halt_req   (halt_req),
    .cnt_clr    (cnt_clr),
    .pc_write   (pc_write),
    .if_flush   (if_flush),
    .npc_sel    (npc_sel),
    .halt_ack   (halt_ack),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected for that cycle.
  task automatic drive(input string tag,
                       input logic st, input logic jp, input logic cx, input logic cm,
                       input logic hr, input logic clr,
                       input logic e_pcw, input logic e_fl, input logic [1:0] e_sel,
                       input logic e_ack);
    exp_t e;
    id_stall    = st;
    jpc_avail   = jp;
    correct_ex  = cx;
    correct_mem = cm;
    halt_req    = hr;
    cnt_clr     = clr;
    e.tag  = tag;
    e.outs = {e_pcw, e_fl, e_sel, e_ack};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, {27'd0, pc_write, if_flush, npc_sel, halt_ack}, {27'd0, e.outs});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    id_stall = 0; jpc_avail = 0; correct_ex = 0; correct_mem = 0; halt_req = 0; cnt_clr = 0;
    #1;
    check("rst_outs", {28'd0, pc_write, if_flush, npc_sel}, {28'd0, 4'b0100});
    check("rst_ack", halt_ack, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Boot bubble then first sequential fetch.
    drive("boot_c0", 0,0,0,0,0,0, 0,1,2'd0,0);
    drive("run_c1",  0,0,0,0,0,0, 1,0,2'd0,0);

    // Redirect priority.
    drive("prio_all", 1,1,1,1,0,0, 1,1,2'd3,0);
    check("flush_cnt_prio", flush_cnt, 1);
    drive("ex_only",  0,1,1,0,0,0, 1,1,2'd2,0);
    drive("jpc_only", 0,1,0,0,0,0, 1,0,2'd1,0);
    check("flush_cnt_ex", flush_cnt, 2);

    // Load-use stall ignores the jump target.
    for (int i = 0; i < 3; i++) drive("load_use", 1,1,0,0,0,0, 0,0,2'd0,0);
    check("stall_cnt_lu", stall_cnt, 3);

    // Halt handshake with a correction in HALT cycle 2.
    drive("halt_enter", 0,0,0,0,1,0, 0,0,2'd0,0);
    drive("halt_c1",    0,1,0,0,1,0, 0,0,2'd0,0);
    drive("halt_c2_ex", 0,0,1,0,1,0, 1,1,2'd2,0);
    for (int i = 0; i < 3; i++) drive("halt_drain", 0,0,0,0,1,0, 0,0,2'd0,0);
    drive("halt_ack1",  0,0,0,0,1,0, 0,0,2'd0,1);
    drive("halt_ack_sat", 0,0,0,0,1,0, 0,0,2'd0,1);
    drive("ack_mem",    0,0,0,1,1,0, 1,1,2'd3,1);
    for (int i = 0; i < 3; i++) drive("redrain", 0,0,0,0,1,0, 0,0,2'd0,0);
    drive("reack",      0,0,0,0,1,0, 0,0,2'd0,1);
    drive("halt_drop",  0,0,0,0,0,0, 0,0,2'd0,1);
    drive("resume",     0,0,0,0,0,0, 1,0,2'd0,0);
    check("flush_cnt_halt", flush_cnt, 4);

    // Halt withdrawn before ack.
    drive("halt2_enter", 0,0,0,0,1,0, 0,0,2'd0,0);
    drive("halt2_drop",  0,0,0,0,0,0, 0,0,2'd0,0);
    drive("resume2",     0,1,0,0,0,0, 1,0,2'd1,0);
    check("stall_cnt_halt", stall_cnt, 5);

    // Saturation and clear.
    for (int i = 0; i < 20; i++) drive("sat_stall", 1,0,0,0,0,0, 0,0,2'd0,0);
    check("stall_cnt_sat", stall_cnt, 15);
    drive("clr_stall", 1,0,0,0,0,1, 0,0,2'd0,0);
    check("stall_cnt_clr", stall_cnt, 0);
    check("flush_cnt_clr", flush_cnt, 0);
    drive("post_clr", 1,0,0,0,0,0, 0,0,2'd0,0);
    check("stall_cnt_post", stall_cnt, 1);

    // Async reset while acknowledged in HALT.
    drive("h3_enter", 0,0,0,0,1,0, 0,0,2'd0,0);
    for (int i = 0; i < 3; i++) drive("h3_drain", 0,0,0,0,1,0, 0,0,2'd0,0);
    check("h3_ack", halt_ack, 1);
    #2 rst = 1'b0;
    #1;
    check("async_ack", halt_ack, 0);
    check("async_outs", {28'd0, pc_write, if_flush, npc_sel}, {28'd0, 4'b0100});
    check("async_stall_cnt", stall_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive("reboot_c0", 0,1,0,0,1,0, 0,1,2'd0,0);
    drive("reboot_halt", 0,0,0,0,0,0, 0,0,2'd0,0);
    drive("reboot_run", 0,0,0,0,0,0, 1,0,2'd0,0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
